// File: rtl/select_encoder_block_if.sv
// Select/encode bus bundle for the MiniSRC register-file select logic.
// Control side drives IR and strobes; the block returns enables and status.
interface select_encoder_block_if;
  logic [31:0] IR;
  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;
  logic        BAout;
  logic [15:0] Rin_Sig;
  logic [15:0] Rout_Sig;
  logic        ba_zero;
  logic [3:0]  sel_idx_q;
  logic        sel_valid_q;

  modport master (
    output IR, Gra, Grb, Grc, Rin, Rout, BAout,
    input  Rin_Sig, Rout_Sig, ba_zero,
    input  sel_idx_q, sel_valid_q
  );

  modport slave (
    input  IR, Gra, Grb, Grc, Rin, Rout, BAout,
    output Rin_Sig, Rout_Sig, ba_zero,
    output sel_idx_q, sel_valid_q
  );
endinterface

// File: rtl/select_encoder_block.sv
// MiniSRC select-and-encode: Ra/Rb/Rc field pick, 4-to-16 decode, status.
// Optional sticky strobe-conflict flag under SEL_ENC_CONFLICT_DET_EN.
module select_encoder_block #(
  parameter int RA_LSB = 23,
  parameter int RB_LSB = 19,
  parameter int RC_LSB = 15
) (
  input  logic clk,
  input  logic clr_n,
  select_encoder_block_if.slave bus
`ifdef SEL_ENC_CONFLICT_DET_EN
  ,
  output logic conflict_q
`endif
);

  logic [3:0]  w_sel;
  logic        w_any_g;
  logic [15:0] w_dec;
  logic        w_multi;

  assign w_any_g = bus.Gra | bus.Grb | bus.Grc;
  assign w_multi = (bus.Gra & bus.Grb) |
                   (bus.Gra & bus.Grc) |
                   (bus.Grb & bus.Grc);

  // Field pick with Gra over Grb over Grc.
  always_comb begin
    w_sel = 4'd0;
    if (bus.Gra)
      w_sel = bus.IR[RA_LSB +: 4];
    else if (bus.Grb)
      w_sel = bus.IR[RB_LSB +: 4];
    else if (bus.Grc)
      w_sel = bus.IR[RC_LSB +: 4];
  end

  // One-hot decode, all-zero when nothing is selected.
  always_comb begin
    w_dec = 16'd0;
    if (w_any_g)
      w_dec[w_sel] = 1'b1;
  end

  assign bus.Rin_Sig  = w_dec & {16{bus.Rin}};
  assign bus.Rout_Sig = w_dec & {16{bus.Rout | bus.BAout}};
  assign bus.ba_zero  = bus.BAout & w_any_g & (w_sel == 4'd0);

  // Remember the last selection; valid only for the cycle it happened.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      bus.sel_idx_q   <= 4'd0;
      bus.sel_valid_q <= 1'b0;
    end else if (w_any_g) begin
      bus.sel_idx_q   <= w_sel;
      bus.sel_valid_q <= 1'b1;
    end else begin
      bus.sel_valid_q <= 1'b0;
    end
  end

`ifdef SEL_ENC_CONFLICT_DET_EN
  // Sticky flag: more than one strobe seen since the last reset.
  always_ff @(posedge clk) begin
    if (!clr_n)
      conflict_q <= 1'b0;
    else if (w_multi)
      conflict_q <= 1'b1;
  end
`else
  logic w_unused;
  assign w_unused = w_multi;
`endif

endmodule

// File: tb/tb_select_encoder_block.sv
// Randomized + directed bench for select_encoder_block.
// Reference model computes fields by shifting IR and tracks status state.
module tb_select_encoder_block;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  select_encoder_block_if bus();

`ifdef SEL_ENC_CONFLICT_DET_EN
  logic conflict_q;
`endif

  select_encoder_block dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
`ifdef SEL_ENC_CONFLICT_DET_EN
    ,
    .conflict_q (conflict_q)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  int m_idx;
  int m_valid;
  int m_conf;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_pick(logic [31:0] ir, logic a, logic b, logic c);
    if (a) return int'((ir / (32'd1 << 23)) % 16);
    if (b) return int'((ir / (32'd1 << 19)) % 16);
    if (c) return int'((ir / (32'd1 << 15)) % 16);
    return 0;
  endfunction

  // Apply inputs at negedge, check combinational outputs, then clock.
  task automatic step(logic [31:0] ir, logic a, logic b, logic c,
                      logic ri, logic ro, logic ba, logic rn);
    int sel;
    int any;
    int nstr;
    logic [31:0] dec;
    @(negedge clk);
    bus.IR = ir;
    bus.Gra = a;
    bus.Grb = b;
    bus.Grc = c;
    bus.Rin = ri;
    bus.Rout = ro;
    bus.BAout = ba;
    clr_n = rn;
    #1;
    nstr = int'(a) + int'(b) + int'(c);
    any = (nstr > 0) ? 1 : 0;
    sel = m_pick(ir, a, b, c);
    dec = (any != 0) ? (32'd1 << sel) : 32'd0;
    chk("rin_sig", {16'd0, bus.Rin_Sig}, ri ? dec : 32'd0);
    chk("rout_sig", {16'd0, bus.Rout_Sig}, (ro | ba) ? dec : 32'd0);
    chk("ba_zero", {31'd0, bus.ba_zero},
        (ba && any != 0 && sel == 0) ? 32'd1 : 32'd0);
    @(posedge clk);
    if (!rn) begin
      m_idx = 0;
      m_valid = 0;
      m_conf = 0;
    end else begin
      if (any != 0) begin
        m_idx = sel;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      if (nstr > 1) m_conf = 1;
    end
    #1;
    chk("sel_idx_q", {28'd0, bus.sel_idx_q}, 32'(m_idx));
    chk("sel_valid_q", {31'd0, bus.sel_valid_q}, 32'(m_valid));
`ifdef SEL_ENC_CONFLICT_DET_EN
    chk("conflict_q", {31'd0, conflict_q}, 32'(m_conf));
`endif
  endtask

  initial begin
    m_idx = 0;
    m_valid = 0;
    m_conf = 0;
    clr_n = 1'b0;
    bus.IR = '0;
    bus.Gra = 0; bus.Grb = 0; bus.Grc = 0;
    bus.Rin = 0; bus.Rout = 0; bus.BAout = 0;

    step(32'h0, 0, 0, 0, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++)
      step(32'(i) << 23, 1, 0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 16; i++)
      step(32'(i) << 19, 0, 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 16; i++)
      step(32'(i) << 15, 0, 0, 1, 1, 0, 0, 1);

    step(32'hFFFF_FFFF, 0, 0, 0, 1, 1, 1, 1);

    step(32'h0, 0, 1, 0, 0, 0, 1, 1);
    step(32'd5 << 19, 0, 1, 0, 0, 0, 1, 1);

    step((32'd3 << 23) | (32'd7 << 19) | (32'd9 << 15),
         1, 1, 1, 1, 0, 0, 1);

    step(32'd6 << 23, 1, 0, 0, 1, 1, 1, 0);
    step(32'd6 << 23, 1, 0, 0, 1, 1, 1, 1);

    for (int k = 0; k < 400; k++) begin
      step($urandom,
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 2) == 0),
           1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 15) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/select_encoder_block.md
Name: select_encoder_block

Overview:
- Select-and-encode logic for the MiniSRC datapath register file.
- Extracts the Ra, Rb or Rc field from the instruction register, chosen by control-unit strobes Gra/Grb/Grc.
- Decodes the field 4-to-16 and gates it with Rin, Rout and BAout to produce per-register load (Rin_Sig) and bus-drive (Rout_Sig) enables.
- Also holds a small registered status of the most recent selection for the control unit and debug.

Parameters:
- RA_LSB, 23, bit position of the LSB of the 4-bit Ra field in IR (field is IR[26:23]).
- RB_LSB, 19, bit position of the LSB of the 4-bit Rb field (IR[22:19]).
- RC_LSB, 15, bit position of the LSB of the 4-bit Rc field (IR[18:15]).

Ports:
- clk  in  1  system clock; status registers update on the rising edge.
- clr_n  in  1  synchronous active-low reset.
- IR  in  32  instruction register contents.
- Gra  in  1  select the Ra field.
- Grb  in  1  select the Rb field.
- Grc  in  1  select the Rc field.
- Rin  in  1  load enable for the selected register.
- Rout  in  1  bus-drive enable for the selected register.
- BAout  in  1  base-address drive enable (same decode as Rout).
- Rin_Sig  out  16  one-hot register load enables.
- Rout_Sig  out  16  one-hot register drive enables.
- ba_zero  out  1  BAout active with R0 selected; the bus must read 0.
- sel_idx_q  out  4  registered index of the last valid selection.
- sel_valid_q  out  1  registered: a field was selected on the last clock.

Behaviour:
- The reset is synchronous and active-low; it only affects the registered status outputs, as described below.
- Field selection is combinational, with priority Gra > Grb > Grc:
  - sel = Gra ? IR[RA_LSB+3:RA_LSB] : Grb ? IR[RB_LSB+3:RB_LSB] : Grc ? IR[RC_LSB+3:RC_LSB] : 4'd0.
  - any_g = Gra | Grb | Grc.
- Decode is combinational: dec = any_g ? (16'b1 << sel) : 16'b0.
- Rin_Sig = dec & {16{Rin}}.
- Rout_Sig = dec & {16{Rout | BAout}}.
- Rin_Sig and Rout_Sig have zero latency. They are pure functions of the current inputs and are independent of clk and clr_n, including during reset.
- Rin and Rout may both be asserted together; the same bit then appears in both outputs.
- Outputs are exactly one-hot or all-zero; never more than one bit set.
- ba_zero = BAout & any_g & (sel == 0). It is combinational. Rout_Sig[0] still asserts, and the R0 wrapper forces 0 onto the bus.
- IR bits outside the selected field have no effect.
- Status registers, on the rising edge of clk:
  - If clr_n == 0: sel_idx_q <= 0 and sel_valid_q <= 0. This overrides all other updates, including in the same cycle as an active selection.
  - Else if any_g: sel_idx_q <= sel and sel_valid_q <= 1.
  - Else: sel_idx_q holds and sel_valid_q <= 0.
- There are no X-propagation exceptions. All outputs are defined for every input combination.

Optional Feature:
- Macro SEL_ENC_CONFLICT_DET_EN.
- When defined, adds output port conflict_q (1 bit), a sticky error flag:
  - Set on the clock edge where more than one of Gra/Grb/Grc is high.
  - Cleared only by clr_n == 0 (synchronous).
  - Priority selection is unchanged.
- When not defined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- For i = 0..15: IR = i<<23, Gra = Rin = Rout = 1 -> Rin_Sig == Rout_Sig == 1<<i combinationally, with no clock edge needed.
- For i = 0..15: IR = i<<19, Grb = Rin = 1, Rout = BAout = 0 -> Rin_Sig == 1<<i and Rout_Sig == 0. Repeat with IR = i<<15 and Grc = 1 -> same results.
- All G strobes 0, Rin = Rout = BAout = 1, IR = 32'hFFFFFFFF -> Rin_Sig == 0, Rout_Sig == 0, ba_zero == 0; after one clock, sel_valid_q == 0.
- IR = 32'h0, Grb = 1, BAout = 1 -> Rout_Sig == 16'h0001 and ba_zero == 1. Then IR = 5<<19 -> Rout_Sig == 16'h0020 and ba_zero == 0.
- Priority: IR = (3<<23)|(7<<19)|(9<<15), Gra = Grb = Grc = Rin = 1 -> Rin_Sig == 16'h0008. Clock once -> sel_idx_q == 3, sel_valid_q == 1; conflict_q == 1 if the macro is defined.
- Reset: hold clr_n = 0 across a clock edge with Gra = 1 -> sel_idx_q == 0, sel_valid_q == 0, conflict_q cleared; Rin_Sig still follows the inputs.
